// File: rtl/pc_gen_bp.sv
// Fetch-PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// The BTB is trained by the resolving stage; lookup is combinational on the current PC.
module pc_gen_bp #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam int N     = 1 << BTB_IDX_W;
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  // PC and targets are stored word-aligned, so bits [1:0] are implicitly zero.
  logic [29:0]                 r_pc;
  logic [N-1:0]                r_valid;
  logic [N-1:0][TAG_W-1:0]     r_tag;
  logic [N-1:0][29:0]          r_tgt;
  logic [N-1:0][1:0]           r_ctr;

  logic [BTB_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic [BTB_IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0]     w_utag;
  logic                 w_uhit;
  logic [1:0]           w_uctr;

  assign w_idx = r_pc[BTB_IDX_W-1:0];
  assign w_tag = r_pc[29:BTB_IDX_W];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign pc          = {r_pc, 2'b00};
  assign pred_taken  = w_hit && r_ctr[w_idx][1];
  assign pred_target = pred_taken ? {r_tgt[w_idx], 2'b00} : 32'h0;

  assign w_uidx = upd_pc[BTB_IDX_W+1:2];
  assign w_utag = upd_pc[31:BTB_IDX_W+2];
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_uctr = r_ctr[w_uidx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC[31:2];
    end else if (redirect_valid) begin
      r_pc <= redirect_pc[31:2];
    end else if (!pc_stall) begin
      r_pc <= pred_taken ? r_tgt[w_idx] : r_pc + 30'd1;
    end
  end

  // Training writes land after the edge, so same-cycle lookups see old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_tgt   <= '0;
      r_ctr   <= '0;
    end else if (upd_valid) begin
      if (w_uhit) begin
        if (upd_taken) begin
          if (w_uctr != 2'b11) r_ctr[w_uidx] <= w_uctr + 2'd1;
          r_tgt[w_uidx] <= upd_target[31:2];
        end else if (w_uctr != 2'b00) begin
          r_ctr[w_uidx] <= w_uctr - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_uidx] <= 1'b1;
        r_tag[w_uidx]   <= w_utag;
        r_tgt[w_uidx]   <= upd_target[31:2];
        r_ctr[w_uidx]   <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen_bp.sv
// Scoreboard bench for pc_gen_bp: directed scenarios followed by random traffic
// checked against an array-based reference of the BTB and next-PC rules.
module tb_pc_gen_bp;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_stall, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] pc, pred_target;
  logic        pred_taken;

  pc_gen_bp #(.RESET_PC(RPC), .BTB_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .pc(pc), .pred_taken(pred_taken),
    .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] pg;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference state: 16 entries, tag is everything above the index bits.
  logic [31:0] m_pc;
  bit          m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  function automatic void m_look(input logic [31:0] p, output bit t, output logic [31:0] g);
    int i;
    i = int'(p[5:2]);
    t = m_v[i] && (m_tag[i] == p[31:6]) && (m_ctr[i] >= 2);
    g = t ? m_tgt[i] : 32'h0;
  endfunction

  function automatic void m_reset();
    m_pc = RPC & 32'hFFFF_FFFC;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
  endfunction

  function automatic exp_t m_exp();
    exp_t e;
    bit t;
    logic [31:0] g;
    m_look(m_pc, t, g);
    e.pc = m_pc; e.pt = t; e.pg = g;
    return e;
  endfunction

  function automatic void m_step(input bit st, input bit rv, input logic [31:0] rpc,
                                 input bit uv, input logic [31:0] upc,
                                 input logic [31:0] utgt, input bit ut);
    bit t;
    logic [31:0] g;
    int i;
    m_look(m_pc, t, g);
    if (rv)       m_pc = rpc & 32'hFFFF_FFFC;
    else if (!st) m_pc = t ? g : m_pc + 32'd4;
    if (uv) begin
      i = int'(upc[5:2]);
      if (m_v[i] && m_tag[i] == upc[31:6]) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = utgt & 32'hFFFF_FFFC;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ut) begin
        m_v[i] = 1; m_tag[i] = upc[31:6];
        m_tgt[i] = utgt & 32'hFFFF_FFFC; m_ctr[i] = 2;
      end
    end
  endfunction

  // Drive one cycle of inputs (also releases reset) and queue the post-edge expectation.
  task automatic drv(input bit st, input bit rv, input logic [31:0] rpc,
                     input bit uv, input logic [31:0] upc,
                     input logic [31:0] utgt, input bit ut);
    @(negedge clk); #1;
    rst = 1'b1;
    pc_stall = st; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = ut;
    m_step(st, rv, rpc, uv, upc, utgt, ut);
    exp_q.push_back(m_exp());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input logic [31:0] a);
    drv(0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] a, input logic [31:0] t, input bit tk);
    drv(1, 0, 0, 1, a, t, tk);
  endtask

  // Monitor: DUT outputs are a function of state only, so compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("pred_taken", {31'h0, pred_taken}, {31'h0, e.pt});
        chk("pred_target", pred_target, e.pg);
      end
    end
  end

  logic [31:0] addrs [8];

  initial begin
    addrs[0] = 32'h40;  addrs[1] = 32'h440; addrs[2] = 32'h80;  addrs[3] = 32'h100;
    addrs[4] = 32'h300; addrs[5] = 32'h3C;  addrs[6] = 32'hFFFF_FFFC; addrs[7] = 32'h203;
    rst = 1'b0;
    pc_stall = 0; redirect_valid = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
    #1;
    m_reset();
    exp_q.push_back(m_exp());

    // Sequential fetch out of reset, then stall and stall+redirect priority.
    idle(4);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 32'h203, 0, 0, 0, 0);

    // Allocate on the same edge as a redirect onto that PC.
    drv(0, 1, 32'h40, 1, 32'h40, 32'h100, 1);
    idle(1);

    // Counter hysteresis and not-taken miss.
    drv(0, 1, 32'h40, 1, 32'h40, 32'h100, 0);
    idle(1);
    train(32'h40, 32'h100, 1);
    train(32'h40, 32'h100, 1);
    train(32'h40, 32'h100, 0);
    redir(32'h40);
    idle(1);
    train(32'h80, 32'h200, 0);
    redir(32'h80);
    idle(1);

    // Aliasing: same index, new tag replaces the old entry.
    train(32'h440, 32'h300, 1);
    redir(32'h40);
    idle(1);
    redir(32'h440);
    // Lookup and training on the same index in one cycle: old contents used.
    drv(0, 0, 0, 1, 32'h440, 32'h500, 0);
    idle(1);

    // PC wrap.
    redir(32'hFFFF_FFFC);
    idle(2);

    // Random traffic over a small address set so hits and aliasing are common.
    for (int k = 0; k < 400; k++) begin
      drv($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          addrs[$urandom_range(0, 7)] | $urandom_range(0, 3),
          $urandom_range(0, 2) == 0, addrs[$urandom_range(0, 7)],
          addrs[$urandom_range(0, 7)] | $urandom_range(0, 3),
          $urandom_range(0, 3) != 0);
    end

    // Train an entry, sit on it, then async reset between edges with work pending.
    train(32'h440, 32'h300, 1);
    redir(32'h440);
    @(negedge clk); #1;
    redirect_valid = 1; redirect_pc = 32'h80;
    upd_valid = 1; upd_pc = 32'h80; upd_target = 32'h100; upd_taken = 1;
    rst = 1'b0;
    #1;
    chk("async_rst_pc", pc, RPC);
    chk("async_rst_pred", {31'h0, pred_taken}, 32'h0);
    m_reset();
    exp_q.push_back(m_exp());
    idle(2);
    redir(32'h440);
    idle(2);

    @(negedge clk); #2;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
